program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Program loader: receives a byte stream (16-bit word count, then big-endian
// 16-bit instructions) and writes the words into instruction memory. It raises
// ready when the program is fully loaded and error when the load is aborted.
// Optional feature macro LOADER_CHECKSUM_EN: when it is defined, a trailing
// XOR checksum byte is required, and this byte is checked in the CHK state.
module program_loader #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              ready,
  output logic              error
);

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StDone,
    StErr
`ifdef LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  localparam logic [16:0] MaxLen = 17'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       rem_q;      // words still to be received
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        data_hi_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic        too_long;
  logic        last_word;

  assign accept    = in_valid & in_ready;
  assign start_ok  = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  assign len_full  = {len_hi_q, in_data};
  assign too_long  = {1'b0, len_full} > MaxLen;
  assign last_word = (rem_q == 16'd1);

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; in_valid low leaves the state untouched
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) begin
          if (too_long) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) state_d = StDataLo;
      end
      StDataLo: begin
        if (accept) begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StDataHi;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (in_data == chk_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Status outputs; ready waits out the final write strobe before rising
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StDataHi, StDataLo: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:                                in_ready = 1'b1;
`endif
      default:                              in_ready = 1'b0;
    endcase
    ready = (state_q == StDone) & ~wr_en_q;
    error = (state_q == StErr);
  end

  // Datapath: length capture, word assembly, write strobe and word index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi_q  <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      data_hi_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      wr_en_q <= accept & (state_q == StDataLo);
      if (start_ok) begin
        idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        chk_q <= '0;
`endif
      end
      if (accept) begin
        case (state_q)
          StLenHi: len_hi_q <= in_data;
          StLenLo: rem_q <= len_full;
          StDataHi: begin
            data_hi_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= chk_q ^ in_data;
`endif
          end
          StDataLo: begin
            wr_data_q <= {data_hi_q, in_data};
            wr_addr_q <= idx_q;
            rem_q     <= rem_q - 16'd1;
            // Index stops on the last word so it never reaches MEM_DEPTH
            if (!last_word) idx_q <= idx_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= chk_q ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
